// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for the multicycle RV32I core.
//
// Sequences FETCH -> DECODE -> EXEC [-> MEM | BRANCH] -> FETCH and drives the
// datapath selects/enables. The datapath, ALU, immgen and register file are
// external; this block only decides what happens in each cycle.
//
// Ports:
//   CLK, RES_N     clock, asynchronous active-low reset
//   INSTR          IR contents (valid from the cycle after IR_WE)
//   MEM_READY      memory accepts/completes the current request
//   BR_TAKEN       ALU compare result, sampled in EXEC of a branch
//   IMM_MODE       immgen mode (IMM_* codes)
//   ALU_A_SEL      0 RS1, 1 PC, 2 OLD_PC, 3 zero
//   ALU_B_SEL      0 RS2, 1 IMM
//   ALU_OP_SEL     0 ADD, 1 funct3/funct7, 2 branch compare
//   MEM_REQ/MEM_WE/MEM_ADDR_SEL  memory handshake, store flag, 0 PC / 1 ALU
//   IR_WE, PC_WE, REG_WE, WB_SEL  architectural write enables, rd source
//   TRAP           illegal-instruction halt
//   STATE          FSM state for debug
module multicycle_ctrl #(
    parameter int unsigned RESET_STALL = 0
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic [31:0] INSTR,
    input  logic        MEM_READY,
    input  logic        BR_TAKEN,
    output logic [2:0]  IMM_MODE,
    output logic [1:0]  ALU_A_SEL,
    output logic        ALU_B_SEL,
    output logic [1:0]  ALU_OP_SEL,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic        MEM_ADDR_SEL,
    output logic        IR_WE,
    output logic        PC_WE,
    output logic        REG_WE,
    output logic [1:0]  WB_SEL,
    output logic        TRAP,
    output logic [2:0]  STATE
);

    // immgen mode codes, same encoding as the IMM_* defines of the core
    localparam logic [2:0] IMM_ZERO    = 3'd0;
    localparam logic [2:0] IMM_I       = 3'd1;
    localparam logic [2:0] IMM_S       = 3'd2;
    localparam logic [2:0] IMM_B       = 3'd3;
    localparam logic [2:0] IMM_U       = 3'd4;
    localparam logic [2:0] IMM_J       = 3'd5;
    localparam logic [2:0] IMM_CONST_4 = 3'd6;

    localparam logic [1:0] A_RS1   = 2'd0;
    localparam logic [1:0] A_PC    = 2'd1;
    localparam logic [1:0] A_OLDPC = 2'd2;
    localparam logic [1:0] A_ZERO  = 2'd3;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_FUNCT = 2'd1;
    localparam logic [1:0] OP_BR    = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef enum logic [2:0] {
        S_STALL  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD,
        C_STORE, C_OPIMM, C_OP, C_FENCE, C_ILL
    } cls_t;

    localparam state_t     RST_STATE  = (RESET_STALL > 0) ? S_STALL : S_FETCH;
    localparam logic [3:0] STALL_LAST = 4'((RESET_STALL > 0) ? RESET_STALL - 1 : 0);

    function automatic cls_t decode(input logic [6:0] opc);
        case (opc)
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BRANCH;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0010011: return C_OPIMM;
            7'b0110011: return C_OP;
            7'b0001111: return C_FENCE;
            default:    return C_ILL;   // includes SYSTEM and INSTR[1:0]!=2'b11
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input cls_t c);
        case (c)
            C_LUI, C_AUIPC:         return IMM_U;
            C_JAL:                  return IMM_J;
            C_JALR, C_LOAD, C_OPIMM: return IMM_I;
            C_STORE:                return IMM_S;
            C_BRANCH:               return IMM_B;
            default:                return IMM_ZERO;
        endcase
    endfunction

    state_t     state, state_nxt;
    cls_t       cls, dec_cls;
    logic [3:0] stall_cnt;
    logic       br_flag;

    // only the opcode field steers sequencing
    logic instr_unused;
    assign instr_unused = ^INSTR[31:7];

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state     <= RST_STATE;
            stall_cnt <= '0;
            cls       <= C_FENCE;
            br_flag   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_STALL)
                stall_cnt <= stall_cnt + 4'd1;
            if (state == S_DECODE)
                cls <= dec_cls;
            if (state == S_EXEC && cls == C_BRANCH)
                br_flag <= BR_TAKEN;
        end
    end

    // ALU operand/op setup of the latched class; shared by EXEC and MEM so the
    // effective address stays stable while memory is waiting
    logic [1:0] cls_a, cls_op;
    logic       cls_b;
    logic [2:0] cls_imm;

    always_comb begin
        cls_a   = A_RS1;
        cls_b   = 1'b0;
        cls_op  = OP_ADD;
        cls_imm = imm_of(cls);
        case (cls)
            C_OP:                    cls_op = OP_FUNCT;
            C_OPIMM:                 begin cls_b = 1'b1; cls_op = OP_FUNCT; end
            C_LUI:                   begin cls_a = A_ZERO;  cls_b = 1'b1; end
            C_AUIPC, C_JAL:          begin cls_a = A_OLDPC; cls_b = 1'b1; end
            C_JALR, C_LOAD, C_STORE: cls_b = 1'b1;
            C_BRANCH:                cls_op = OP_BR;
            default:                 ;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        dec_cls      = decode(INSTR[6:0]);
        IMM_MODE     = IMM_ZERO;
        ALU_A_SEL    = A_RS1;
        ALU_B_SEL    = 1'b0;
        ALU_OP_SEL   = OP_ADD;
        MEM_REQ      = 1'b0;
        MEM_WE       = 1'b0;
        MEM_ADDR_SEL = 1'b0;
        IR_WE        = 1'b0;
        PC_WE        = 1'b0;
        REG_WE       = 1'b0;
        WB_SEL       = WB_ALU;
        TRAP         = 1'b0;

        case (state)
            S_STALL: begin
                if (stall_cnt == STALL_LAST)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                MEM_REQ = 1'b1;
                if (MEM_READY) begin
                    // PC <= PC + 4 in the same cycle the IR is loaded
                    IR_WE      = 1'b1;
                    PC_WE      = 1'b1;
                    ALU_A_SEL  = A_PC;
                    ALU_B_SEL  = 1'b1;
                    IMM_MODE   = IMM_CONST_4;
                    state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                IMM_MODE  = imm_of(dec_cls);
                state_nxt = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                IMM_MODE   = cls_imm;
                ALU_A_SEL  = cls_a;
                ALU_B_SEL  = cls_b;
                ALU_OP_SEL = cls_op;
                state_nxt  = S_FETCH;
                case (cls)
                    C_OP, C_OPIMM, C_LUI, C_AUIPC: REG_WE = 1'b1;
                    C_JAL, C_JALR: begin
                        // ALU computes the target; rd takes the already
                        // incremented PC (OLD_PC+4)
                        PC_WE  = 1'b1;
                        REG_WE = 1'b1;
                        WB_SEL = WB_PC;
                    end
                    C_BRANCH:        state_nxt = S_BRANCH;
                    C_LOAD, C_STORE: state_nxt = S_MEM;
                    default:         ;
                endcase
            end
            S_MEM: begin
                IMM_MODE     = cls_imm;
                ALU_A_SEL    = cls_a;
                ALU_B_SEL    = cls_b;
                ALU_OP_SEL   = cls_op;
                MEM_REQ      = 1'b1;
                MEM_ADDR_SEL = 1'b1;
                MEM_WE       = (cls == C_STORE);
                if (MEM_READY) begin
                    if (cls == C_LOAD) begin
                        REG_WE = 1'b1;
                        WB_SEL = WB_MEM;
                    end
                    state_nxt = S_FETCH;
                end
            end
            S_BRANCH: begin
                IMM_MODE  = IMM_B;
                ALU_A_SEL = A_OLDPC;
                ALU_B_SEL = 1'b1;
                PC_WE     = br_flag;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                TRAP = 1'b1;
            end
            default: state_nxt = S_TRAP;
        endcase

        // Reset must kill an outstanding request at once, not at the next
        // edge, so every output is forced idle while RES_N is low.
        if (!RES_N) begin
            IMM_MODE     = IMM_ZERO;
            ALU_A_SEL    = A_RS1;
            ALU_B_SEL    = 1'b0;
            ALU_OP_SEL   = OP_ADD;
            MEM_REQ      = 1'b0;
            MEM_WE       = 1'b0;
            MEM_ADDR_SEL = 1'b0;
            IR_WE        = 1'b0;
            PC_WE        = 1'b0;
            REG_WE       = 1'b0;
            WB_SEL       = WB_ALU;
            TRAP         = 1'b0;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds a per-cycle list of expected outputs from
// the instruction-level rules (instruction, memory wait counts, branch
// outcome), then replays it against the DUT.
module tb_multicycle_ctrl;

    localparam int unsigned STALL = 3;

    localparam logic [2:0] IZ = 3'd0, II = 3'd1, IS = 3'd2, IB = 3'd3,
                           IU = 3'd4, IJ = 3'd5, I4 = 3'd6;

    localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111,
                           O_JAL = 7'b1101111, O_JALR  = 7'b1100111,
                           O_BR  = 7'b1100011, O_LOAD  = 7'b0000011,
                           O_ST  = 7'b0100011, O_OPIMM = 7'b0010011,
                           O_OP  = 7'b0110011, O_FENCE = 7'b0001111;
    localparam logic [6:0] LEGAL [10] = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR,
                                          O_LOAD, O_ST, O_OPIMM, O_OP, O_FENCE};

    logic        CLK = 1'b0;
    logic        RES_N = 1'b1;
    logic [31:0] INSTR = '0;
    logic        MEM_READY = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [2:0]  IMM_MODE;
    logic [1:0]  ALU_A_SEL;
    logic        ALU_B_SEL;
    logic [1:0]  ALU_OP_SEL;
    logic        MEM_REQ, MEM_WE, MEM_ADDR_SEL, IR_WE, PC_WE, REG_WE;
    logic [1:0]  WB_SEL;
    logic        TRAP;
    logic [2:0]  STATE;

    multicycle_ctrl #(.RESET_STALL(STALL)) dut (
        .CLK(CLK), .RES_N(RES_N), .INSTR(INSTR), .MEM_READY(MEM_READY),
        .BR_TAKEN(BR_TAKEN), .IMM_MODE(IMM_MODE), .ALU_A_SEL(ALU_A_SEL),
        .ALU_B_SEL(ALU_B_SEL), .ALU_OP_SEL(ALU_OP_SEL), .MEM_REQ(MEM_REQ),
        .MEM_WE(MEM_WE), .MEM_ADDR_SEL(MEM_ADDR_SEL), .IR_WE(IR_WE),
        .PC_WE(PC_WE), .REG_WE(REG_WE), .WB_SEL(WB_SEL), .TRAP(TRAP),
        .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] imm;
        logic [1:0] a;
        logic       b;
        logic [1:0] op;
        logic       req, we, asel, irwe, pcwe, regwe;
        logic [1:0] wb;
        logic       trap;
        logic [2:0] st;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        br;
        logic [31:0] instr;
        obs_t        exp;
        string       tag;
    } step_t;

    obs_t obs;
    assign obs = {IMM_MODE, ALU_A_SEL, ALU_B_SEL, ALU_OP_SEL, MEM_REQ, MEM_WE,
                  MEM_ADDR_SEL, IR_WE, PC_WE, REG_WE, WB_SEL, TRAP, STATE};

    step_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input obs_t e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic push(input logic rst, input logic rdy, input logic br,
                        input logic [31:0] ins, input obs_t e, input string tag);
        step_t s;
        s.rst = rst; s.rdy = rdy; s.br = br; s.instr = ins; s.exp = e; s.tag = tag;
        q.push_back(s);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t at(input logic [2:0] st);
        obs_t o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic bit is_legal(input logic [6:0] opc);
        foreach (LEGAL[i]) if (LEGAL[i] == opc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] imm_for(input logic [6:0] opc);
        case (opc)
            O_LUI, O_AUIPC:         return IU;
            O_JAL:                  return IJ;
            O_JALR, O_LOAD, O_OPIMM: return II;
            O_BR:                   return IB;
            O_ST:                   return IS;
            default:                return IZ;
        endcase
    endfunction

    // operands of the instruction's main ALU step (EXEC, and held in MEM)
    function automatic obs_t alu_step(input logic [6:0] opc, input logic [2:0] st);
        obs_t o = at(st);
        o.imm = imm_for(opc);
        case (opc)
            O_OP:    o.op = 2'd1;
            O_OPIMM: begin o.b = 1'b1; o.op = 2'd1; end
            O_LUI:   begin o.a = 2'd3; o.b = 1'b1; end
            O_AUIPC, O_JAL: begin o.a = 2'd2; o.b = 1'b1; end
            O_JALR, O_LOAD, O_ST: o.b = 1'b1;
            O_BR:    o.op = 2'd2;
            default: ;
        endcase
        return o;
    endfunction

    // reset held low for n cycles, then released into the stall window
    task automatic push_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b0, rnd(), rnd(), 32'h0, at(3'd0), "reset");
        for (int i = 0; i < int'(STALL); i++) push(1'b1, rnd(), rnd(), 32'h0, at(3'd0), "stall");
    endtask

    task automatic push_fetch_wait(input logic [31:0] ins, input int n);
        obs_t o;
        for (int i = 0; i < n; i++) begin
            o = at(3'd1); o.req = 1'b1;
            push(1'b1, 1'b0, rnd(), ins, o, "fetch_wait");
        end
    endtask

    task automatic push_instr(input logic [31:0] ins, input int fw, input int mw,
                              input logic br);
        obs_t o;
        logic [6:0] opc = ins[6:0];
        push_fetch_wait(ins, fw);
        o = at(3'd1); o.req = 1'b1; o.irwe = 1'b1; o.pcwe = 1'b1;
        o.a = 2'd1; o.b = 1'b1; o.imm = I4;
        push(1'b1, 1'b1, rnd(), ins, o, "fetch");
        o = at(3'd2); o.imm = imm_for(opc);
        push(1'b1, rnd(), rnd(), ins, o, "decode");
        if (!is_legal(opc)) begin
            for (int i = 0; i < 20; i++) begin
                o = at(3'd6); o.trap = 1'b1;
                push(1'b1, rnd(), rnd(), ins, o, "trap");
            end
            return;
        end
        o = alu_step(opc, 3'd3);
        case (opc)
            O_OP, O_OPIMM, O_LUI, O_AUIPC: o.regwe = 1'b1;
            O_JAL, O_JALR: begin o.pcwe = 1'b1; o.regwe = 1'b1; o.wb = 2'd2; end
            default: ;
        endcase
        push(1'b1, rnd(), br, ins, o, "exec");
        if (opc == O_LOAD || opc == O_ST) begin
            for (int i = 0; i <= mw; i++) begin
                o = alu_step(opc, 3'd4);
                o.req = 1'b1; o.asel = 1'b1; o.we = (opc == O_ST);
                if (i == mw && opc == O_LOAD) begin o.regwe = 1'b1; o.wb = 2'd1; end
                push(1'b1, (i == mw), rnd(), ins, o, (i == mw) ? "mem" : "mem_wait");
            end
        end else if (opc == O_BR) begin
            o = at(3'd5); o.a = 2'd2; o.b = 1'b1; o.imm = IB; o.pcwe = br;
            push(1'b1, rnd(), rnd(), ins, o, "branch");
        end
    endtask

    // inputs change and outputs are sampled just after the falling edge
    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge CLK);
            RES_N = s.rst; MEM_READY = s.rdy; BR_TAKEN = s.br; INSTR = s.instr;
            #1;
            check(s.tag, s.exp);
        end
    endtask

    // reset pulled low between edges must idle the outputs right away
    task automatic async_pulse(input string tag);
        #2;
        RES_N = 1'b0;
        #1;
        check(tag, at(3'd0));
    endtask

    initial begin
        logic [31:0] r;
        #2 RES_N = 1'b0;
        #1 check("reset_async", at(3'd0));

        push_reset(2);
        push_instr(32'h00500093, 0, 0, 1'b0);   // addi x1,x0,5
        push_instr(32'h0000A103, 0, 2, 1'b0);   // lw, two memory wait cycles
        push_instr(32'h00208463, 1, 0, 1'b1);   // beq taken
        push_instr(32'h00208463, 0, 0, 1'b0);   // beq not taken
        push_instr(32'h008000EF, 2, 0, 1'b0);   // jal x1,8
        push_instr(32'h00112223, 0, 1, 1'b0);   // sw
        run_q();

        for (int n = 0; n < 80; n++) begin
            r = $urandom();
            push_instr({r[31:7], LEGAL[$urandom_range(0, 9)]},
                       $urandom_range(0, 2), $urandom_range(0, 2), rnd());
        end
        run_q();

        push_instr(32'h00000073, 0, 0, 1'b0);   // ecall -> trap
        run_q();
        async_pulse("trap_reset");
        push_reset(1);
        push_instr(32'hFFFFFFFC, 1, 0, 1'b0);   // INSTR[1:0]!=11 -> trap
        run_q();
        async_pulse("trap_reset2");
        push_reset(1);
        push_fetch_wait(32'h00500093, 2);
        run_q();
        async_pulse("fetch_abort");
        push_reset(1);
        push_instr(32'h00500093, 0, 0, 1'b0);
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I core. It sequences fetch, decode, execute and memory phases.
- It drives immgen MODE (IMM_MODE), ALU operand/op selects, PC/IR/register-file write enables and the shared memory request handshake.
- The datapath, ALU, immgen and register file are external. This block owns the sequencing only.

Parameters:
- RESET_STALL, 0: number of idle cycles after reset release before the first FETCH request (0..15).

Ports:
- CLK  in  1  system clock
- RES_N  in  1  asynchronous active-low reset
- INSTR  in  32  instruction register contents (stable from the cycle after IR_WE)
- MEM_READY  in  1  memory accepts/completes the current request in this cycle
- BR_TAKEN  in  1  ALU compare result (valid while ALU_OP_SEL=2)
- IMM_MODE  out  3  immgen MODE, using the `IMM_*` codes from proc_defines.v
- ALU_A_SEL  out  2  ALU A operand: 0 RS1, 1 PC, 2 OLD_PC, 3 zero
- ALU_B_SEL  out  1  ALU B operand: 0 RS2, 1 IMM
- ALU_OP_SEL  out  2  ALU operation: 0 ADD, 1 from funct3/funct7, 2 branch compare
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  store request, qualified by MEM_REQ
- MEM_ADDR_SEL  out  1  memory address source: 0 PC, 1 ALU result
- IR_WE  out  1  load IR and OLD_PC (OLD_PC <= PC)
- PC_WE  out  1  PC <= ALU result (datapath clears bit 0)
- REG_WE  out  1  register file write of rd
- WB_SEL  out  2  rd write data: 0 ALU, 1 memory load data, 2 PC
- TRAP  out  1  illegal instruction halt
- STATE  out  3  FSM state (debug)

Behaviour:
- States: STALL=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, BRANCH=5, TRAP=6. Encoding is fixed.
- Reset (async, RES_N=0):
  - State goes to STALL if RESET_STALL>0, otherwise FETCH.
  - Stall counter clears. Branch flag clears. TRAP=0.
  - All enables and requests are 0. All selects are 0. IMM_MODE=`IMM_ZERO.
- Outputs are a Moore/Mealy mix. Enables are combinational from state, the registered opcode class and MEM_READY. Unlisted outputs are 0 in every state.
- STALL: count to RESET_STALL-1, then go to FETCH.
- FETCH:
  - MEM_REQ=1, MEM_ADDR_SEL=0.
  - MEM_REQ stays high until MEM_READY; there is no timeout.
  - In the MEM_READY cycle: IR_WE=1 and PC_WE=1, with A=PC, B=IMM, IMM_MODE=`IMM_CONST_4 and ADD, so PC <= PC+4. Next state is DECODE.
- DECODE:
  - Register the opcode class from INSTR[6:0]: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE.
  - INSTR[1:0]!=2'b11, any other opcode, or SYSTEM (1110011) goes to TRAP.
  - Otherwise go to EXEC. IMM_MODE already reflects the class in this cycle.
- EXEC, by class. IMM_MODE is held per class for EXEC, MEM and BRANCH.
  - OP: A=RS1, B=RS2, op=1, REG_WE=1, WB_SEL=0, then FETCH.
  - OP-IMM: A=RS1, B=IMM(I), op=1, REG_WE=1, then FETCH.
  - LUI: A=zero, B=IMM(U), ADD, REG_WE=1, then FETCH.
  - AUIPC: A=OLD_PC, B=IMM(U), ADD, REG_WE=1, then FETCH.
  - JAL: A=OLD_PC, B=IMM(J), ADD, PC_WE=1, REG_WE=1, WB_SEL=2 (rd gets the pre-update PC = OLD_PC+4), then FETCH.
  - JALR: as JAL with A=RS1, B=IMM(I).
  - BRANCH: A=RS1, B=RS2, op=2. Latch BR_TAKEN into the branch flag, then go to BRANCH.
  - LOAD: A=RS1, B=IMM(I), ADD, then MEM.
  - STORE: A=RS1, B=IMM(S), ADD, then MEM.
  - FENCE: no-op, then FETCH.
- MEM:
  - ALU inputs held as in EXEC. MEM_REQ=1, MEM_ADDR_SEL=1, MEM_WE=1 for STORE.
  - Wait for MEM_READY. For LOAD, REG_WE=1 and WB_SEL=1 in the MEM_READY cycle. Then FETCH.
- BRANCH: A=OLD_PC, B=IMM(B), ADD, PC_WE=branch flag, then FETCH.
- TRAP: absorbing. TRAP=1 and all enables are 0 until reset.
- Latency with zero-wait memory:
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, FENCE: 3 cycles.
  - LOAD, STORE, BRANCH: 4 cycles.
  - Each wait cycle adds one.
- MEM_READY outside FETCH/MEM is ignored.
- Reset asserted mid-FETCH or mid-MEM aborts the request asynchronously: MEM_REQ drops immediately.
- IMM_MODE is never X. States without an immediate drive `IMM_ZERO.

Test Plan:
- Reset with RESET_STALL=3, MEM_READY=1 -> STATE=0 for 3 cycles after RES_N rises, then FETCH asserts MEM_REQ=1, IR_WE=1, PC_WE=1, IMM_MODE=`IMM_CONST_4.
- INSTR=0x00500093 (addi x1,x0,5), zero-wait memory -> REG_WE=1 in the 3rd cycle with ALU_B_SEL=1, IMM_MODE=`IMM_I, ALU_OP_SEL=1, WB_SEL=0.
- INSTR=0x0000A103 (lw), MEM_READY held low 2 cycles in MEM -> MEM_REQ=1, MEM_ADDR_SEL=1 steady for 3 cycles; REG_WE=1, WB_SEL=1 only in the MEM_READY cycle; 6 cycles total.
- INSTR=0x00208463 (beq) with BR_TAKEN=1, then the same with BR_TAKEN=0 -> BRANCH state PC_WE=1 resp. 0; IMM_MODE=`IMM_B, ALU_A_SEL=2 in BRANCH.
- INSTR=0x008000EF (jal x1,8) -> EXEC: PC_WE=1, REG_WE=1, WB_SEL=2, IMM_MODE=`IMM_J, ALU_A_SEL=2; next state FETCH.
- INSTR=0x00000073 (ecall), then INSTR=0xFFFFFFFC -> TRAP=1, STATE=6, no enables for 20 cycles; RES_N pulse low mid-FETCH drops MEM_REQ immediately and clears TRAP.
